// File: rtl/mem_arb_pkg.sv
// rtl/mem_arb_pkg.sv - shared widths, limits and state type for the memory arbiter
package mem_arb_pkg;

  localparam int ADDR_W    = 5;
  localparam int DATA_W    = 8;
  localparam int MEM_DEPTH = 32;
  localparam int MAX_REQ   = 4;
  localparam int IDX_W     = $clog2(MAX_REQ);

  typedef enum logic {
    INIT = 1'b0,
    RUN  = 1'b1
  } state_t;

endpackage

// File: rtl/mem_rr_arbiter.sv
// rtl/mem_rr_arbiter.sv - round-robin one-hot grant with last-granted pointer
module mem_rr_arbiter
  import mem_arb_pkg::*;
#(
  parameter int NUM_REQ = 2
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [NUM_REQ-1:0] req,
  input  logic               en,
  output logic [NUM_REQ-1:0] gnt
);

  logic [IDX_W-1:0] last;
  logic [IDX_W-1:0] pick;
  logic             found;
  int               idx;

  // Search from the requester after the last winner, wrapping around
  always_comb begin
    gnt   = '0;
    pick  = last;
    found = 1'b0;
    idx   = 0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      idx = (int'(last) + k) % NUM_REQ;
      if (!found && en && req[idx]) begin
        found    = 1'b1;
        gnt[idx] = 1'b1;
        pick     = IDX_W'(idx);
      end
    end
  end

  // Pointer moves only when the grant is actually taken
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last <= IDX_W'(NUM_REQ - 1);
    end else if (|(req & gnt)) begin
      last <= pick;
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// rtl/mem_arbiter.sv - round-robin access to a 32x8 memory; MEM_ARB_INIT_EN adds a post-reset clear sweep
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int NUM_REQ = 2
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [NUM_REQ-1:0]        req,
  input  logic [NUM_REQ-1:0]        we,
  input  logic [NUM_REQ*ADDR_W-1:0] addr,
  input  logic [NUM_REQ*DATA_W-1:0] wdata,
  output logic [NUM_REQ-1:0]        gnt,
  output logic [NUM_REQ-1:0]        rvalid,
  output logic [DATA_W-1:0]         rdata,
  output logic                      init_done,
  output logic                      mem_read,
  output logic                      mem_write,
  output logic [ADDR_W-1:0]         mem_addr,
  output logic [DATA_W-1:0]         mem_data_in,
  input  logic [DATA_W-1:0]         mem_data_out
);

  logic              run;
  logic              sweep_wr;
  logic [ADDR_W-1:0] sweep_addr;
  logic              accept;
  logic [IDX_W-1:0]  win_idx;
  logic              win_we;
  logic [ADDR_W-1:0] win_addr;
  logic [DATA_W-1:0] win_wdata;
  logic [IDX_W-1:0]  rd_tag;
  logic [DATA_W-1:0] rdata_q;

`ifdef MEM_ARB_INIT_EN
  state_t            state;
  state_t            state_nxt;
  logic [ADDR_W-1:0] sweep_cnt;

  // State register and clear-sweep address counter
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= INIT;
      sweep_cnt <= '0;
    end else begin
      state <= state_nxt;
      if (sweep_wr) sweep_cnt <= sweep_cnt + 1'b1;
    end
  end

  // Keep issuing clear writes until the last-address strobe is on the pins
  always_comb begin
    state_nxt = state;
    sweep_wr  = 1'b0;
    if (state == INIT) begin
      if (mem_write && (mem_addr == ADDR_W'(MEM_DEPTH - 1))) state_nxt = RUN;
      else                                                    sweep_wr  = 1'b1;
    end
  end

  assign run        = (state == RUN);
  assign sweep_addr = sweep_cnt;
`else
  assign run        = 1'b1;
  assign sweep_wr   = 1'b0;
  assign sweep_addr = '0;
`endif

  assign init_done = run;

  mem_rr_arbiter #(.NUM_REQ(NUM_REQ)) u_rr (
    .clk  (clk),
    .rst_n(rst_n),
    .req  (req),
    .en   (run),
    .gnt  (gnt)
  );

  assign accept = |(req & gnt);

  // Route the granted requester's command fields
  always_comb begin
    win_idx   = '0;
    win_we    = 1'b0;
    win_addr  = '0;
    win_wdata = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (gnt[i]) begin
        win_idx   = IDX_W'(i);
        win_we    = we[i];
        win_addr  = addr[i*ADDR_W +: ADDR_W];
        win_wdata = wdata[i*DATA_W +: DATA_W];
      end
    end
  end

  // Memory command registers; strobes pulse for one cycle, address/data hold when idle
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem_read    <= 1'b0;
      mem_write   <= 1'b0;
      mem_addr    <= '0;
      mem_data_in <= '0;
      rd_tag      <= '0;
    end else begin
      mem_read  <= 1'b0;
      mem_write <= 1'b0;
      if (sweep_wr) begin
        mem_write   <= 1'b1;
        mem_addr    <= sweep_addr;
        mem_data_in <= '0;
      end else if (accept) begin
        mem_write   <= win_we;
        mem_read    <= !win_we;
        mem_addr    <= win_addr;
        mem_data_in <= win_we ? win_wdata : '0;
        rd_tag      <= win_idx;
      end
    end
  end

  // Tag returning read data to its issuer and keep the last returned byte
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rvalid  <= '0;
      rdata_q <= '0;
    end else begin
      for (int i = 0; i < NUM_REQ; i++) begin
        rvalid[i] <= mem_read && (rd_tag == IDX_W'(i));
      end
      if (|rvalid) rdata_q <= mem_data_out;
    end
  end

  assign rdata = (|rvalid) ? mem_data_out : rdata_q;

endmodule
